// File: rtl/alu_seq.sv
// Multi-cycle ALU: 1-cycle arithmetic/logic, 1 bit/cycle shifts, iterative shift-add multiply.
// Done one cycle after the accepting edge plus n (shift) or WIDTH (MUL); start ignored while busy.
module alu_seq #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_SLT = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1001;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_FIN} state_t;

  state_t             state;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   sh;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_c;
  logic               sc_v;
  logic               sc_ill;
  logic               is_shift;
  logic               is_mul;
  logic               sh_big;
  logic [CW-1:0]      sh_n;
  logic [WIDTH-1:0]   sh_nxt;
  logic [2*WIDTH-1:0] acc_nxt;

  assign sum      = {1'b0, A} + {1'b0, B};
  assign diff     = {1'b0, A} - {1'b0, B};
  assign sh_big   = (B >= WIDTH'(WIDTH));
  assign sh_n     = {1'b0, B[SHW-1:0]};
  assign is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  assign is_mul   = MUL_EN && (op == OP_MUL);

  // Result of anything that completes at the accepting edge.
  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_ill = 1'b0;
    case (op)
      OP_ADD: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff[WIDTH-1:0];
        sc_c   = diff[WIDTH];
        sc_v   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLL, OP_SRL, OP_SRA: begin
        if (sh_big) sc_res = (op == OP_SRA) ? {WIDTH{A[WIDTH-1]}} : '0;
        else        sc_res = A;
      end
      OP_AND: sc_res = A & B;
      OP_OR:  sc_res = A | B;
      OP_XOR: sc_res = A ^ B;
      OP_MUL: sc_ill = !MUL_EN;
      default: sc_ill = 1'b1;
    endcase
  end

  always_comb begin
    sh_nxt = {1'b0, sh[WIDTH-1:1]};
    if (op_q == OP_SLL)      sh_nxt = {sh[WIDTH-2:0], 1'b0};
    else if (op_q == OP_SRA) sh_nxt = {sh[WIDTH-1], sh[WIDTH-1:1]};
  end

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
      op_q     <= '0;
      sh       <= '0;
      mplier   <= '0;
      mcand    <= '0;
      acc      <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_FIN: begin
          state <= S_IDLE;
          if (start) begin
            op_q <= op;
            if (is_shift && !sh_big && (sh_n != '0)) begin
              sh    <= A;
              cnt   <= sh_n;
              busy  <= 1'b1;
              state <= S_SHIFT;
            end else if (is_mul) begin
              mcand  <= {{WIDTH{1'b0}}, A};
              mplier <= B;
              acc    <= '0;
              cnt    <= CW'(WIDTH);
              busy   <= 1'b1;
              state  <= S_MUL;
            end else begin
              result   <= sc_res;
              zero     <= !sc_ill && (sc_res == '0);
              carry    <= sc_c;
              overflow <= sc_v;
              illegal  <= sc_ill;
              done     <= 1'b1;
              state    <= S_FIN;
            end
          end
        end
        S_SHIFT: begin
          sh  <= sh_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            result   <= sh_nxt;
            zero     <= (sh_nxt == '0);
            carry    <= 1'b0;
            overflow <= 1'b0;
            illegal  <= 1'b0;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= S_FIN;
          end
        end
        S_MUL: begin
          acc    <= acc_nxt;
          mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
          mplier <= {1'b0, mplier[WIDTH-1:1]};
          cnt    <= cnt - 1'b1;
          // Last partial product: publish straight from the adder output.
          if (cnt == CW'(1)) begin
            result   <= acc_nxt[WIDTH-1:0];
            zero     <= (acc_nxt[WIDTH-1:0] == '0);
            carry    <= |acc_nxt[2*WIDTH-1:WIDTH];
            overflow <= |acc_nxt[2*WIDTH-1:WIDTH];
            illegal  <= 1'b0;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= S_FIN;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
